ysyx_23060221_mem_arbiter: RTL and testbench
============================================

YSYX_23060221_MEM_ARBITER -- requirements
Module: ysyx_23060221_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width (DATA_W/8 mask bits).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have IFU request ports: ifu_req_valid in 1; ifu_req_ready out 1; ifu_addr in ADDR_W (IFU is read-only).
REQ-006 SHALL have IFU response ports: ifu_resp_valid out 1; ifu_resp_ready in 1; ifu_rdata out DATA_W.
REQ-007 SHALL have LSU request ports: lsu_req_valid in 1; lsu_req_ready out 1; lsu_addr in ADDR_W; lsu_wen in 1; lsu_wdata in DATA_W; lsu_wmask in DATA_W/8.
REQ-008 SHALL have LSU response ports: lsu_resp_valid out 1; lsu_resp_ready in 1; lsu_rdata out DATA_W.
REQ-009 SHALL have memory request ports: mem_req_valid out 1; mem_req_ready in 1; mem_addr out ADDR_W; mem_wen out 1; mem_wdata out DATA_W; mem_wmask out DATA_W/8.
REQ-010 SHALL have memory response ports: mem_resp_valid in 1; mem_resp_ready out 1; mem_rdata in DATA_W.
REQ-011 SHALL have port busy out 1, high whenever state != IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, WAIT; exactly one transaction outstanding at any time.
REQ-013 IDLE: ifu_req_ready/lsu_req_ready high only for the chosen requester; grant when valid&ready; go to REQ next cycle.
REQ-014 Choice when only one requester is valid: that requester.
REQ-015 Choice when both are valid in the same cycle: round-robin; the master not granted last wins; the last_grant reset value is IFU, so the LSU wins the first tie.
REQ-016 On grant SHALL latch addr, wen, wdata, wmask and owner; IFU grant latches wen=0, wmask=0, wdata=0.
REQ-017 REQ: mem_req_valid=1 with latched fields held stable until mem_req_ready; on handshake go to WAIT.
REQ-018 WAIT: mem_resp_valid routed to the owner's resp_valid only; mem_rdata routed to the owner's rdata; mem_resp_ready = owner resp_ready.
REQ-019 WAIT: on mem_resp_valid&mem_resp_ready go to IDLE and update last_grant=owner.
REQ-020 Non-owner resp_valid SHALL be 0 at all times; non-owner rdata SHALL be 0.
REQ-021 Minimum latency: grant cycle N, mem_req_valid at N+1, response forwarded combinationally in the same cycle as mem_resp_valid.
REQ-022 A new grant SHALL not occur in the cycle in which the response handshake completes; the earliest next grant is the following cycle.
REQ-023 Requester valid deasserted before grant: no transaction and no state change.
REQ-024 mem_resp_valid outside WAIT SHALL be ignored, with mem_resp_ready=0.
REQ-025 Write transactions (wen=1) also complete only on the response handshake; rdata content for writes is don't-care but SHALL still be routed.

Reset
REQ-026 rst low SHALL immediately force state=IDLE, last_grant=IFU, latched fields=0, and all valid/ready outputs=0 except IDLE-derived req_ready.
REQ-027 Reset mid-transaction SHALL abandon the transaction; no response SHALL be delivered after reset release.
REQ-028 The first grant SHALL occur no earlier than the first rising edge after rst deasserts.

Structure
REQ-029 State encoding (IDLE/REQ/WAIT) and owner encoding (IFU=0, LSU=1) SHALL live in a shared package with the bus width constants.
REQ-030 The round-robin choose logic SHALL be one sub-module, ysyx_23060221_rr_pick2 (inputs req[1:0], last; output gnt[1:0]).

Verification
REQ-031 Single IFU read: ifu addr 0x80000000, mem_req_ready=1, response 3 cycles later with rdata 0xDEADBEEF -> ifu_rdata=0xDEADBEEF, lsu_resp_valid stays 0.
REQ-032 Simultaneous requests after reset -> LSU granted first, IFU second; then both again -> IFU granted, strict alternation over 8 transactions.
REQ-033 LSU write addr 0x80001000, wdata 0x12345678, wmask 0xF, mem_req_ready low for 4 cycles -> mem fields stable across all 4 cycles, single mem handshake.
REQ-034 Owner resp_ready held low 5 cycles while mem_resp_valid=1 -> mem_resp_ready=0 throughout, state stays WAIT, completion on first ready.
REQ-035 rst asserted during WAIT -> busy=0 immediately, and a late mem_resp_valid is ignored (mem_resp_ready=0, no resp_valid).
REQ-036 Spurious mem_resp_valid in IDLE -> no resp_valid on either master, mem_resp_ready=0.

Source files
------------

// File: rtl/ysyx_23060221_mem_arbiter_pkg.sv
// rtl/ysyx_23060221_mem_arbiter_pkg.sv - shared encodings and widths for the IFU/LSU memory arbiter
package ysyx_23060221_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_23060221_rr_pick2.sv
// rtl/ysyx_23060221_rr_pick2.sv - two-way round-robin pick; bit 0 is IFU, bit 1 is LSU
module ysyx_23060221_rr_pick2
  import ysyx_23060221_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // On a tie the master that did not win last time goes first.
    if (req == 2'b11) begin
      gnt = (last == OWN_IFU) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ysyx_23060221_mem_arbiter.sv
// rtl/ysyx_23060221_mem_arbiter.sv - single-outstanding IFU/LSU arbiter onto one memory port
module ysyx_23060221_mem_arbiter
  import ysyx_23060221_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                busy
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;

  logic [1:0] gnt;
  logic       idle, in_wait, own_lsu;

  ysyx_23060221_rr_pick2 u_pick (
    .req  ({lsu_req_valid, ifu_req_valid}),
    .last (last_q),
    .gnt  (gnt)
  );

  assign idle    = (state_q == ST_IDLE);
  assign in_wait = (state_q == ST_WAIT);
  assign own_lsu = (owner_q == OWN_LSU);
  assign busy    = !idle;

  // Ready is only offered to the picked master, so a grant is simply gnt while idle.
  assign ifu_req_ready = idle & gnt[0];
  assign lsu_req_ready = idle & gnt[1];

  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  assign mem_resp_ready = in_wait & (own_lsu ? lsu_resp_ready : ifu_resp_ready);
  assign ifu_resp_valid = in_wait & !own_lsu & mem_resp_valid;
  assign lsu_resp_valid = in_wait &  own_lsu & mem_resp_valid;
  assign ifu_rdata      = (in_wait && !own_lsu) ? mem_rdata : '0;
  assign lsu_rdata      = (in_wait &&  own_lsu) ? mem_rdata : '0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt[1]) begin
          owner_d = OWN_LSU;
          addr_d  = lsu_addr;
          wen_d   = lsu_wen;
          wdata_d = lsu_wdata;
          wmask_d = lsu_wmask;
          state_d = ST_REQ;
        end else if (gnt[0]) begin
          owner_d = OWN_IFU;
          addr_d  = ifu_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_resp_valid && mem_resp_ready) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IFU;
      last_q  <= OWN_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060221_mem_arbiter.sv
// tb/tb_ysyx_23060221_mem_arbiter.sv - directed self-checking bench for the memory arbiter
module tb_ysyx_23060221_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;

  ysyx_23060221_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_ready (ifu_resp_ready),
    .ifu_rdata      (ifu_rdata),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_ready (lsu_resp_ready),
    .lsu_rdata      (lsu_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_rdata      (mem_rdata),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_req_valid && mem_req_ready) hs_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives the memory side of one transaction, starting at a falling edge.
  task automatic serve(input logic [31:0] rd, input bit lsu_own, input int dly);
    int n = 0;
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    repeat (dly) begin
      check("wait_busy", busy, 1);
      @(negedge clk);
    end
    mem_resp_valid = 1'b1;
    mem_rdata      = rd;
    #1;
    check("own_valid",   lsu_own ? lsu_resp_valid : ifu_resp_valid, 1);
    check("other_valid", lsu_own ? ifu_resp_valid : lsu_resp_valid, 0);
    check("own_rdata",   lsu_own ? lsu_rdata : ifu_rdata, rd);
    check("other_rdata", lsu_own ? ifu_rdata : lsu_rdata, 0);
    check("mem_resp_rdy", mem_resp_ready, 1);
    check("no_grant_at_done", {ifu_req_ready, lsu_req_ready}, 0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    check("done_idle", busy, 0);
  endtask

  initial begin
    int hs0;
    bit exp_lsu;
    rst = 1'b0;
    ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 1;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_resp_ready = 1;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    check("rst_busy",     busy, 0);
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_req_rdy",  {ifu_req_ready, lsu_req_ready}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Spurious response while idle
    mem_resp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1;
    check("spur_mem_rdy", mem_resp_ready, 0);
    check("spur_ifu_v",   ifu_resp_valid, 0);
    check("spur_lsu_v",   lsu_resp_valid, 0);
    @(negedge clk);
    check("spur_busy", busy, 0);
    mem_resp_valid = 1'b0; mem_rdata = 0;

    // Single IFU read
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    #1;
    check("ifu_rdy", ifu_req_ready, 1);
    check("lsu_rdy", lsu_req_ready, 0);
    @(negedge clk);
    ifu_req_valid = 1'b0;
    check("rd_mem_valid", mem_req_valid, 1);
    check("rd_mem_addr",  mem_addr, 32'h8000_0000);
    check("rd_mem_wen",   mem_wen, 0);
    check("rd_mem_wmask", mem_wmask, 0);
    check("rd_mem_wdata", mem_wdata, 0);
    serve(32'hDEAD_BEEF, 1'b0, 2);

    // Both requesting continuously: LSU first, then strict alternation
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_lsu = (i % 2 == 0);
      #1;
      check("rr_lsu_rdy", lsu_req_ready, exp_lsu);
      check("rr_ifu_rdy", ifu_req_ready, !exp_lsu);
      @(negedge clk);
      check("rr_addr", mem_addr, exp_lsu ? 32'h8000_0200 : 32'h8000_0100);
      serve(32'hA000_0000 + i, exp_lsu, 0);
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

    // LSU write with memory stalling the request for 4 cycles
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
    lsu_wdata = 32'h1234_5678; lsu_wmask = 4'hF;
    #1;
    check("wr_lsu_rdy", lsu_req_ready, 1);
    @(negedge clk);
    lsu_req_valid = 1'b0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    hs0 = hs_cnt;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("wr_valid", mem_req_valid, 1);
      check("wr_addr",  mem_addr, 32'h8000_1000);
      check("wr_wdata", mem_wdata, 32'h1234_5678);
      check("wr_wmask", mem_wmask, 4'hF);
      check("wr_wen",   mem_wen, 1);
      @(negedge clk);
    end
    serve(32'h0BAD_0BAD, 1'b1, 0);
    check("wr_single_hs", hs_cnt - hs0, 1);

    // Owner holds resp_ready low while memory presents a response
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
    @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; ifu_resp_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_mem_rdy", mem_resp_ready, 0);
      check("bp_busy",    busy, 1);
      check("bp_ifu_v",   ifu_resp_valid, 1);
      check("bp_lsu_v",   lsu_resp_valid, 0);
      @(negedge clk);
    end
    ifu_resp_ready = 1'b1;
    #1;
    check("bp_mem_rdy_go", mem_resp_ready, 1);
    check("bp_rdata",      ifu_rdata, 32'hCAFE_F00D);
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_rdata = 0;
    check("bp_done", busy, 0);

    // Reset during WAIT abandons the transaction
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0080;
    @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("rw_busy_pre", busy, 1);
    rst = 1'b0;
    #1;
    check("rw_busy",     busy, 0);
    check("rw_mem_rdy",  mem_resp_ready, 0);
    check("rw_mem_val",  mem_req_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    mem_resp_valid = 1'b1; mem_rdata = 32'h7777_7777;
    #1;
    check("late_mem_rdy", mem_resp_ready, 0);
    check("late_ifu_v",   ifu_resp_valid, 0);
    check("late_lsu_v",   lsu_resp_valid, 0);
    @(negedge clk);
    check("late_busy", busy, 0);
    mem_resp_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
